// File: rtl/sd_otf_converter.sv
// sd_otf_converter
// Converts an MSD-first stream of borrow-save signed digits into a
// two's-complement word. Two candidate results are kept: Q, and QM = Q - 1.
// Each digit only appends a bit to one of them, so no carry-propagate adder
// is needed. The finished word is registered on the edge that accepts the
// last digit.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; digit_valid ignored, busy low
// S_CONV | accepting digits; N-th accepted digit completes, back to IDLE
module sd_otf_converter #(
  parameter int N = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_digit_valid,
  input  logic       i_dp,
  input  logic       i_dn,
  output logic       o_busy,
  output logic [N:0] o_q,
  output logic       o_q_valid
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t        r_state;
  logic [N:0]    r_q_acc;
  logic [N:0]    r_qm;
  logic [CW-1:0] r_cnt;

  logic          w_pos;
  logic          w_neg;
  logic          w_accept;
  logic [N:0]    w_q_nxt;
  logic [N:0]    w_qm_nxt;

  // Digit decode and next candidate values; (1,1) and (0,0) both mean zero.
  always_comb begin
    w_pos    = i_dp & ~i_dn;
    w_neg    = i_dn & ~i_dp;
    w_accept = (r_state == S_CONV) & i_digit_valid & ~i_start;
    w_q_nxt  = {r_q_acc[N-1:0], 1'b0};
    w_qm_nxt = {r_qm[N-1:0], 1'b1};
    if (w_pos) begin
      w_q_nxt  = {r_q_acc[N-1:0], 1'b1};
      w_qm_nxt = {r_q_acc[N-1:0], 1'b0};
    end else if (w_neg) begin
      w_q_nxt  = {r_qm[N-1:0], 1'b1};
      w_qm_nxt = {r_qm[N-1:0], 1'b0};
    end
  end

  // Control FSM with registered outputs; start always wins, even over a digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_q_acc   <= '0;
      r_qm      <= '1;
      r_cnt     <= '0;
      o_busy    <= 1'b0;
      o_q       <= '0;
      o_q_valid <= 1'b0;
    end else begin
      o_q_valid <= 1'b0;
      if (i_start) begin
        r_state <= S_CONV;
        r_q_acc <= '0;
        r_qm    <= '1;
        r_cnt   <= '0;
        o_busy  <= 1'b1;
      end else if (w_accept) begin
        r_q_acc <= w_q_nxt;
        r_qm    <= w_qm_nxt;
        r_cnt   <= r_cnt + 1'b1;
        if (r_cnt == LAST) begin
          r_state   <= S_IDLE;
          o_busy    <= 1'b0;
          o_q       <= w_q_nxt;
          o_q_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_otf_converter.sv
// Testbench for sd_otf_converter: integer reference model plus scoreboard.
module tb_sd_otf_converter;
  localparam int N = 12;
  typedef int iq_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       dv = 1'b0;
  logic       dp = 1'b0;
  logic       dn = 1'b0;
  logic       busy;
  logic [N:0] q;
  logic       qv;

  sd_otf_converter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_digit_valid(dv),
    .i_dp(dp), .i_dn(dn), .o_busy(busy), .o_q(q), .o_q_valid(qv)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int exp_q[$];
  int busy_cycles = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: value = running Horner sum of digit values.
  int m_acc, m_cnt;
  bit m_busy, m_qv;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc = 0; m_cnt = 0; m_busy = 0; m_qv = 0;
    end else begin
      m_qv = 0;
      if (start) begin
        m_acc = 0; m_cnt = 0; m_busy = 1;
      end else if (m_busy && dv) begin
        m_acc = 2 * m_acc + (int'(dp) - int'(dn));
        m_cnt++;
        if (m_cnt == N) begin
          exp_q.push_back(m_acc);
          m_busy = 0;
          m_qv = 1;
        end
      end
    end
  end

  // Monitor: pops an expectation whenever the DUT presents q_valid.
  always @(negedge clk) begin
    chk("busy", int'(busy), int'(m_busy));
    chk("q_valid", int'(qv), int'(m_qv));
    if (qv) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL q_valid_unexpected: got q=%0d expected no result", int'($signed(q)));
      end else begin
        chk("q", int'($signed(q)), exp_q.pop_front());
      end
    end
    if (busy) busy_cycles++;
  end

  task automatic cyc(input bit s, input bit v, input int d);
    bit r;
    @(negedge clk);
    start = s; dv = v;
    if (d > 0) begin dp = 1; dn = 0; end
    else if (d < 0) begin dp = 0; dn = 1; end
    else begin r = 1'($urandom_range(0, 1)); dp = r; dn = r; end
  endtask

  task automatic idle();
    cyc(0, 0, 0);
  endtask

  function automatic iq_t rep(input int v, input int n);
    iq_t r;
    for (int i = 0; i < n; i++) r.push_back(v);
    return r;
  endfunction

  task automatic feed(input iq_t ds, input int stall);
    for (int i = 0; i < ds.size(); i++) begin
      while (int'($urandom_range(0, 99)) < stall) cyc(0, 0, int'($urandom_range(0, 2)) - 1);
      if (stall > 0 && i == 6) repeat (4) cyc(0, 0, int'($urandom_range(0, 2)) - 1);
      cyc(0, 1, ds[i]);
    end
  endtask

  task automatic run_op(input iq_t ds, input int stall);
    cyc(1, 0, 0);
    feed(ds, stall);
  endtask

  task automatic expect_q(input string name, input int v);
    idle();
    chk(name, int'($signed(q)), v);
  endtask

  initial begin
    iq_t ds;
    #1;
    chk("reset_q", int'(q), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_qv", int'(qv), 0);
    repeat (3) @(negedge clk);
    rst_n = 1;

    busy_cycles = 0;
    run_op(rep(1, N), 0);
    expect_q("all_ones", 4095);
    chk("busy_cycles", busy_cycles, 12);

    run_op(rep(-1, N), 0);
    expect_q("all_minus", -4095);
    run_op(rep(0, N), 0);
    expect_q("all_zero", 0);

    ds = rep(-1, N - 1); ds.push_front(1);
    run_op(ds, 0);
    expect_q("cancel_plus", 1);
    ds = rep(0, N - 2); ds.push_front(1); ds.push_front(-1);
    run_op(ds, 0);
    expect_q("cancel_minus", -1024);

    run_op(rep(1, N), 50);
    expect_q("stalls", 4095);

    run_op(rep(1, 5), 0);
    cyc(1, 1, 1);
    feed(rep(-1, N), 0);
    expect_q("abort", -4095);

    run_op(rep(1, N), 0);
    @(negedge clk);
    chk("overlap_qv", int'(qv), 1);
    start = 1; dv = 0;
    feed(rep(-1, N), 0);
    expect_q("overlap", -4095);

    run_op(rep(1, 7), 0);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_q", int'(q), 0);
    chk("rst_mid_qv", int'(qv), 0);
    idle(); idle();
    rst_n = 1;
    repeat (3) cyc(0, 1, 1);
    run_op(rep(1, N), 0);
    expect_q("after_reset", 4095);

    for (int k = 0; k < 40; k++) begin
      ds = {};
      for (int i = 0; i < N; i++) ds.push_back(int'($urandom_range(0, 2)) - 1);
      if ($urandom_range(0, 4) == 0) begin
        run_op(rep(1, int'($urandom_range(0, N - 1))), 20);
        cyc(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)) - 1);
        feed(ds, 20);
      end else begin
        run_op(ds, 20);
      end
      if ($urandom_range(0, 1) == 0) idle();
    end
    repeat (3) idle();
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sd_otf_converter.md
# sd_otf_converter

Sequential on-the-fly converter that turns a most-significant-digit-first stream of radix-2 signed digits (borrow-save pairs, the format produced by the redundant adder tree of the parallel and online multipliers) into a conventional two's-complement word. It sits at the output end of the online datapath. It accepts one digit per enabled clock and holds two candidate results, Q and QM = Q − 1. It delivers the converted word in the cycle the last digit is accepted, with no carry-propagate adder.

## Interface
- N, default 12: number of signed digits per operand; must be ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that opens a new conversion.
- digit_valid  input  1  dp/dn carry a digit this cycle.
- dp  input  1  positive component of the digit.
- dn  input  1  negative component of the digit; digit value = dp − dn.
- busy  output  1  high while the block is accepting digits.
- q  output  N+1  converted signed result (two's complement).
- q_valid  output  1  one-cycle pulse: q has just been updated.

## Operation
- **Digit encoding:**
  - (dp,dn) = (1,0) is +1.
  - (0,1) is −1.
  - (0,0) and (1,1) are both 0.
- **Weighting:** digit j (j = 1..N, first received = 1) has weight 2^(N−j). The final value is Σ d_j·2^(N−j), in the range −(2^N − 1)..+(2^N − 1). It fits N+1 bits signed.
- **Internal registers:**
  - Q and QM, each N+1 bits.
  - Digit counter cnt, ⌈log2 N⌉ bits.
  - State register.
- **States:**
  - IDLE: busy = 0. start → clear, go to CONV. digit_valid is ignored.
  - CONV: busy = 1. A digit is accepted on each edge with digit_valid = 1. After the N-th accepted digit, go to IDLE.
- **Clear, on accepted start:** Q ← 0, QM ← all ones (−1), cnt ← 0.
- **Update per accepted digit** ({X,b} = X shifted left one place with b appended, MSB dropped):
  - d = +1: Q ← {Q,1}, QM ← {Q,0}.
  - d = 0: Q ← {Q,0}, QM ← {QM,1}.
  - d = −1: Q ← {QM,1}, QM ← {QM,0}.
- **Invariant:** QM = Q − 1 after every update.
- **Completion:** on the edge that accepts digit N (cnt = N−1):
  - q ← the updated Q value for that digit.
  - q_valid ← 1 for exactly one cycle.
  - State → IDLE.
- **Output hold:** q holds its value until the next completion. It is not cleared by start.
- **Start during CONV:** aborts the current conversion and re-clears Q, QM and cnt. A digit_valid in the same cycle is discarded (start wins). No q_valid is produced for the aborted operand.
- **Gaps:** digit_valid low in CONV stalls the conversion. State, Q, QM and cnt are held, with no timeout.

## Timing
- **Reset values:** state = IDLE, busy = 0, q = 0, q_valid = 0, Q = 0, QM = all ones, cnt = 0. These apply immediately on rst_n low, independent of clk.
- **Reset mid-operation:** the partial conversion is lost and no q_valid is produced. After release, the block waits in IDLE for start.
- **start cycle:** consumes no digit. The first digit can be accepted on the next edge.
- **busy:** rises on the edge after start and falls on the edge that accepts digit N.
- **Latency:**
  - With a back-to-back digit stream: start at edge 0, digits at edges 1..N, q/q_valid visible after edge N.
  - Overall throughput is one operand per N+1 cycles.
- **Overlapping start:** start may be asserted in the cycle q_valid is high. It is accepted because the state is already IDLE.
- **Registering:** q_valid and q are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset then all ones:** reset, start, 12 consecutive digits of +1 (N=12) → q_valid pulses after the 12th digit, q = 4095 (0x0FFF); busy high for exactly 12 cycles.
- **All minus ones:** start, 12 digits of −1 → q = −4095 (13-bit 0x1001); then feed 12 digits of 0 using (1,1) encoding → q = 0.
- **Redundant cancellation:** digit stream +1 followed by eleven −1 → q = 1. Stream −1, +1, then ten 0 → q = −1024 (0x1C00).
- **Stalls:** same stream as the all-ones case with digit_valid low on random cycles, including several consecutive cycles → identical q = 4095; q_valid only after the 12th accepted digit.
- **Restart and overlap:**
  - Start, 5 digits of +1, then start with digit_valid = 1 in the same cycle, then 12 digits of −1 → a single q_valid, q = −4095; the discarded digit does not affect the result.
  - Start asserted in the q_valid cycle → accepted.
- **Reset mid-operation:** assert rst_n low after digit 7 → busy, q_valid and q are 0 immediately; digit_valid while in IDLE is ignored; a new start with 12 × (+1) → q = 4095.
